mplieru8x8_dotacc: RTL and testbench
====================================

// Module: mplieru8x8_dotacc
// PURPOSE
//  Dot-product engine built around the combinational mplieru8x8 unsigned 8x8 multiplier.
//  Upstream, it accepts operand pairs (a,b) on a valid/ready stream and registers them into the multiplier.
//  Downstream, it registers each 16-bit product and accumulates LEN products.
//  It presents the sum on a valid/ready result port; software-facing datapaths use it for u8 vector dot products.
// PARAMETERS
//  LEN    4   number of operand pairs per dot product; legal 1..255
//  ACC_W  24  accumulator/result width; legal 16..32; no overflow when ACC_W >= 16+clog2(LEN)
// PORTS
//  clk        in   1      single clock; all state changes on rising edge
//  rst_n      in   1      synchronous active-low reset
//  start      in   1      begin a new dot product; honoured only in IDLE
//  in_valid   in   1      operand pair a,b valid
//  in_ready   out  1      engine accepts pair this cycle
//  a          in   8      unsigned operand A
//  b          in   8      unsigned operand B
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer takes result
//  result     out  ACC_W  sum of LEN products, modulo 2^ACC_W
//  overflow   out  1      carry out of accumulator seen during this dot product
//  busy       out  1      high in ACCUM and DONE
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state=IDLE; in_ready, out_valid, busy, overflow = 0; result = 0.
//   Accumulator, term count, and pipeline valid bits are cleared.
//   Reset mid-operation discards all in-flight pairs and products in that one edge.
//  FSM states:
//   IDLE: in_ready=0; in_valid is ignored and no pair is consumed.
//    start=1 -> ACCUM; acc, count, and overflow are cleared.
//   ACCUM: in_ready=1 while count<LEN; a pair is accepted when in_valid&in_ready.
//    Accepted pairs are captured into the operand register (stage 1); count increments.
//    Stage 1 drives mplieru8x8. The next edge zero-extends the 16-bit product to ACC_W and adds it into acc (stage 2).
//    Bubbles (in_valid=0) are allowed anywhere; only valid stages add into acc.
//    in_ready drops combinationally once count==LEN.
//    When the LEN-th product is added, the FSM goes to DONE in the same edge; result <= final sum.
//   DONE: out_valid=1 and busy=1; result and overflow are held stable.
//    out_valid&out_ready -> IDLE at the next edge. out_valid and busy drop; result and overflow keep their values until the next DONE.
//  Latency: out_valid rises on the 2nd rising edge after the edge that accepted the LEN-th pair.
//   Minimum cycles from start to out_valid = LEN+2.
//  start outside IDLE is ignored, including in DONE with out_ready=1. No back-to-back chaining.
//  Arithmetic: acc wraps modulo 2^ACC_W. overflow is sticky and set on any carry out of bit ACC_W-1.
//  Product must equal a*b exactly (0..65025); the multiplier is used unmodified.
//  X on a/b while in_valid=0 must not propagate into acc.
// TESTING
//  LEN=4: start, then (255,255) x4 back-to-back.
//   -> result=260100, overflow=0, out_valid exactly 2 edges after 4th accept, 6 cycles after start.
//  LEN=4: pairs (1,2),(3,4),(5,6),(7,8) with in_valid toggled 1/0 each cycle.
//   -> result=100; in_ready=0 after 4th accept.
//  Hold out_ready=0 5 cycles in DONE, pulsing start and in_valid.
//   -> out_valid and result stable, in_ready=0, no new op; out_ready=1 -> IDLE next edge, busy=0.
//  ACC_W=16, LEN=2: (255,255),(255,255) -> result=64514, overflow=1.
//   Next run (1,1),(1,1) -> result=2, overflow=0.
//  rst_n=0 for 1 edge after 2 of 4 accepts -> all outputs 0 next cycle.
//   New run of (0,200) x4 -> result=0, no stale products.
//  LEN=1: sweep all 65536 (a,b) pairs -> result == a*b each run, overflow=0.

Source files
------------

// File: rtl/mplieru8x8_dotacc.sv
`default_nettype none
// ============================================================================
//  Module      : mplieru8x8_dotacc (with helper mplieru8x8)
//  Description : Unsigned u8 dot-product engine. Operand pairs arrive on a
//                valid/ready stream and are registered into a combinational
//                8x8 multiplier. Each product is registered and then added into
//                an ACC_W-bit accumulator. After LEN products, the sum is
//                presented on a valid/ready result port.
//  Revision    : 1.0 - initial release
// ============================================================================

// Combinational unsigned 8x8 -> 16 multiplier; exact for all inputs.
module mplieru8x8 (
    input  logic [7:0]  i_a,
    input  logic [7:0]  i_b,
    output logic [15:0] o_product
);
    assign o_product = 16'(i_a) * 16'(i_b);
endmodule

module mplieru8x8_dotacc #(
    parameter int LEN   = 4,
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             overflow,
    output logic             busy
);
    localparam int         c_SUM_W = ACC_W + 1;
    localparam logic [7:0] c_LEN   = 8'(LEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [7:0]         r_count;
    logic [7:0]         r_a;
    logic [7:0]         r_b;
    logic               r_s1_valid;
    logic               r_s1_last;
    logic [15:0]        r_prod;
    logic               r_s2_valid;
    logic               r_s2_last;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf_run;
    logic [ACC_W-1:0]   r_result;
    logic               r_overflow;

    logic [15:0]        w_product;
    logic [ACC_W:0]     w_sum;
    logic               w_accept;
    logic               w_last_done;
    logic               w_start_op;

    mplieru8x8 u_mul (
        .i_a       (r_a),
        .i_b       (r_b),
        .o_product (w_product)
    );

    // The top bit of the sum is the carry out of the accumulator.
    assign w_sum       = {1'b0, r_acc} + c_SUM_W'(r_prod);
    assign w_accept    = in_valid & in_ready;
    assign w_last_done = r_s2_valid & r_s2_last;
    assign w_start_op  = (r_state == S_IDLE) & start;
    assign result      = r_result;
    assign overflow    = r_overflow;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs; start is only looked at in IDLE.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_ACCUM;
                end
            end
            S_ACCUM: begin
                busy     = 1'b1;
                in_ready = (r_count != c_LEN);
                if (w_last_done) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Term counter and pipeline valid/last tags; reset flushes in-flight work.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count    <= 8'd0;
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_start_op) begin
                r_count <= 8'd0;
            end else if (w_accept) begin
                r_count <= r_count + 8'd1;
            end
            r_s1_valid <= w_accept;
            r_s2_valid <= r_s1_valid;
        end
    end

    // Datapath registers load only with valid data, so idle-bus values never enter.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a       <= a;
            r_b       <= b;
            r_s1_last <= (r_count == c_LEN - 8'd1);
        end
        if (r_s1_valid) begin
            r_prod    <= w_product;
            r_s2_last <= r_s1_last;
        end
    end

    // Accumulate valid products, track carries, and publish the final sum.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_ovf_run  <= 1'b0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_start_op) begin
                r_acc     <= '0;
                r_ovf_run <= 1'b0;
            end else if (r_s2_valid) begin
                r_acc     <= w_sum[ACC_W-1:0];
                r_ovf_run <= r_ovf_run | w_sum[ACC_W];
            end
            if (w_last_done) begin
                r_result   <= w_sum[ACC_W-1:0];
                r_overflow <= r_ovf_run | w_sum[ACC_W];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mplieru8x8_dotacc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mplieru8x8_dotacc
//  Description : Directed, table-driven bench for mplieru8x8_dotacc. Three
//                instances: LEN=4/ACC_W=24, LEN=2/ACC_W=16, LEN=1/ACC_W=24.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mplieru8x8_dotacc;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0]      start     = '0;
    logic [2:0]      in_valid  = '0;
    logic [2:0]      out_ready = '0;
    logic [2:0][7:0] a         = '0;
    logic [2:0][7:0] b         = '0;
    logic [2:0]      in_ready;
    logic [2:0]      out_valid;
    logic [2:0]      busy;
    logic [2:0]      overflow;
    logic [23:0]     res0;
    logic [15:0]     res1;
    logic [23:0]     res2;

    mplieru8x8_dotacc #(.LEN(4), .ACC_W(24)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .a(a[0]), .b(b[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .result(res0), .overflow(overflow[0]), .busy(busy[0]));

    mplieru8x8_dotacc #(.LEN(2), .ACC_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .a(a[1]), .b(b[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .result(res1), .overflow(overflow[1]), .busy(busy[1]));

    mplieru8x8_dotacc #(.LEN(1), .ACC_W(24)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .a(a[2]), .b(b[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .result(res2), .overflow(overflow[2]), .busy(busy[2]));

    typedef struct {
        int              d;
        int              n;
        logic [3:0][7:0] av;
        logic [3:0][7:0] bv;
        bit              gaps;
        longint          exp_res;
        bit              exp_ovf;
        int              hold;
    } vec_t;

    vec_t vecs[8];

    function automatic longint res_of(input int d);
        case (d)
            0:       return longint'(res0);
            1:       return longint'(res1);
            default: return longint'(res2);
        endcase
    endfunction

    function automatic logic [3:0][7:0] pk4(input logic [7:0] x0, input logic [7:0] x1,
                                            input logic [7:0] x2, input logic [7:0] x3);
        pk4 = {x3, x2, x1, x0};
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Start one dot product and feed n pairs; returns once out_valid is seen or the bound expires.
    task automatic run_op(input int d, input int n, input logic [3:0][7:0] av,
                          input logic [3:0][7:0] bv, input bit gaps,
                          output longint res, output bit ovf, output int lat_acc,
                          output int lat_start, output bit rdy_after, output bit ok);
        int idx = 0;
        int e_start;
        int e_acc = 0;
        int guard = 0;
        bit tog = 1'b1;
        bit acc_now;
        start[d] = 1'b1;
        @(posedge clk); #1;
        start[d] = 1'b0;
        e_start = cyc;
        while (idx < n && guard < 100) begin
            in_valid[d] = gaps ? tog : 1'b1;
            a[d] = in_valid[d] ? av[idx] : 8'hA5;
            b[d] = in_valid[d] ? bv[idx] : 8'h5A;
            acc_now = in_valid[d] && in_ready[d];
            tog = ~tog;
            @(posedge clk); #1;
            guard++;
            if (acc_now) begin
                idx++;
                e_acc = cyc;
            end
        end
        in_valid[d] = 1'b0;
        a[d] = 8'hA5;
        b[d] = 8'h5A;
        rdy_after = in_ready[d];
        guard = 0;
        while (!out_valid[d] && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        ok        = out_valid[d];
        lat_acc   = cyc - e_acc;
        lat_start = cyc - e_start;
        res       = res_of(d);
        ovf       = overflow[d];
    endtask

    // Optionally stall in DONE while poking start/in_valid, then take the result.
    task automatic finish_op(input int d, input int hold);
        longint r0 = res_of(d);
        bit     o0 = overflow[d];
        for (int i = 0; i < hold; i++) begin
            start[d]    = i[0];
            in_valid[d] = 1'b1;
            a[d]        = 8'd50;
            b[d]        = 8'd50;
            @(posedge clk); #1;
            check("hold out_valid", out_valid[d], 1);
            check("hold result", res_of(d), r0);
            check("hold in_ready", in_ready[d], 0);
        end
        in_valid[d]  = 1'b0;
        start[d]     = (hold > 0);
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
        start[d]     = 1'b0;
        check("release out_valid", out_valid[d], 0);
        check("release busy", busy[d], 0);
        check("release result kept", res_of(d), r0);
        check("release overflow kept", overflow[d], o0);
        if (hold > 0) begin
            @(posedge clk); #1;
            check("start in DONE ignored", busy[d], 0);
        end
    endtask

    initial begin
        longint r;
        bit     o;
        int     la;
        int     ls;
        bit     ra;
        bit     ok;

        vecs[0] = '{0, 4, pk4(255, 255, 255, 255), pk4(255, 255, 255, 255), 1'b0, 260100, 1'b0, 5};
        vecs[1] = '{0, 4, pk4(1, 3, 5, 7), pk4(2, 4, 6, 8), 1'b1, 100, 1'b0, 0};
        vecs[2] = '{1, 2, pk4(255, 255, 0, 0), pk4(255, 255, 0, 0), 1'b0, 64514, 1'b1, 0};
        vecs[3] = '{1, 2, pk4(1, 1, 0, 0), pk4(1, 1, 0, 0), 1'b0, 2, 1'b0, 0};
        vecs[4] = '{0, 4, pk4(10, 30, 0, 255), pk4(20, 40, 255, 1), 1'b1, 1655, 1'b0, 0};
        vecs[5] = '{1, 2, pk4(255, 2, 0, 0), pk4(255, 255, 0, 0), 1'b1, 65535, 1'b0, 0};
        vecs[6] = '{1, 2, pk4(255, 7, 0, 0), pk4(255, 73, 0, 0), 1'b0, 0, 1'b1, 2};
        vecs[7] = '{2, 1, pk4(255, 0, 0, 0), pk4(255, 0, 0, 0), 1'b0, 65025, 1'b0, 0};

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", out_valid[0], 0);
        check("reset in_ready", in_ready[0], 0);
        check("reset busy", busy[0], 0);
        check("reset overflow", overflow[0], 0);
        check("reset result", res_of(0), 0);
        check("reset result d1", res_of(1), 0);
        rst_n = 1'b1;

        // IDLE ignores in_valid
        in_valid[0] = 1'b1;
        a[0] = 8'd3;
        b[0] = 8'd3;
        @(posedge clk); #1;
        check("idle in_ready", in_ready[0], 0);
        check("idle busy", busy[0], 0);
        in_valid[0] = 1'b0;

        // Table of directed dot products
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].d, vecs[i].n, vecs[i].av, vecs[i].bv, vecs[i].gaps, r, o, la, ls, ra, ok);
            check($sformatf("v%0d done", i), ok, 1);
            check($sformatf("v%0d result", i), r, vecs[i].exp_res);
            check($sformatf("v%0d overflow", i), o, vecs[i].exp_ovf);
            check($sformatf("v%0d in_ready after last", i), ra, 0);
            check($sformatf("v%0d latency from last accept", i), la, 2);
            if (!vecs[i].gaps) begin
                check($sformatf("v%0d latency from start", i), ls, vecs[i].n + 2);
            end
            finish_op(vecs[i].d, vecs[i].hold);
        end

        // Reset after two of four accepts
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0]    = 1'b0;
        in_valid[0] = 1'b1;
        a[0] = 8'd9;
        b[0] = 8'd9;
        repeat (2) @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midreset out_valid", out_valid[0], 0);
        check("midreset in_ready", in_ready[0], 0);
        check("midreset busy", busy[0], 0);
        check("midreset overflow", overflow[0], 0);
        check("midreset result", res_of(0), 0);
        repeat (3) @(posedge clk);
        #1;
        check("midreset no phantom done", out_valid[0], 0);
        run_op(0, 4, pk4(0, 0, 0, 0), pk4(200, 200, 200, 200), 1'b0, r, o, la, ls, ra, ok);
        check("post-reset done", ok, 1);
        check("post-reset result", r, 0);
        check("post-reset overflow", o, 0);
        finish_op(0, 0);

        // LEN=1 product sweep on a coarse grid
        for (int x = 0; x < 256; x += 17) begin
            for (int y = 0; y < 256; y += 17) begin
                run_op(2, 1, pk4(8'(x), 0, 0, 0), pk4(8'(y), 0, 0, 0), 1'b0, r, o, la, ls, ra, ok);
                check($sformatf("sweep %0d*%0d", x, y), r, longint'(x * y));
                check($sformatf("sweep ovf %0d*%0d", x, y), o, 0);
                finish_op(2, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
